// File: rtl/alu_exec_if.sv
// Issue/result bundle between the ID/EX pipeline register and alu_exec_unit.
// master = issuing side, slave = execute unit.
interface alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               valid_in;
    logic [1:0]         ALUOp;
    logic [5:0]         funcCode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               result_valid;
    logic               zero;
    logic               illegal;
    logic               busy;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output valid_in, ALUOp, funcCode, a, b, shamt,
        input  result, result_valid, zero, illegal, busy, hi, lo
    );

    modport slave (
        input  valid_in, ALUOp, funcCode, a, b, shamt,
        output result, result_valid, zero, illegal, busy, hi, lo
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered MIPS execute stage: ALU control decode plus datapath, one-cycle latency.
// Define ALU_MULDIV_EN to build the iterative MULTU/DIVU unit with HI/LO and busy.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_exec_if.slave   bus
);
    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_RTYPE = 2'd2;

    localparam logic [5:0] F_SLL  = 6'd0;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_SRA  = 6'd3;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_XOR  = 6'd38;
    localparam logic [5:0] F_NOR  = 6'd39;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] F_SLTU = 6'd43;

    logic                    issue;
    logic                    start_md;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_illegal;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    logic [WIDTH-1:0]        result_p1;
    logic                    vld_p1;
    logic                    zero_p1;
    logic                    illegal_p1;

    assign a_s = bus.a;
    assign b_s = bus.b;

`ifdef ALU_MULDIV_EN
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;

    localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic               start_mul;
    logic               start_div;
    logic               md_last;
    logic               op_div_q;
    logic [SHAMT_W:0]   cnt_q;
    logic [WIDTH-1:0]   operand_q;
    logic [WIDTH-1:0]   work_hi_q;
    logic [WIDTH-1:0]   work_lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    // Issue is refused for the whole RUN phase; DONE already behaves like IDLE.
    assign issue    = bus.valid_in && (state_q != RUN);
    assign start_md = start_mul | start_div;
    assign md_last  = (state_q == RUN) && (cnt_q == CNT_ONE);
`else
    assign issue    = bus.valid_in;
    assign start_md = 1'b0;
`endif

    // Shifts act on rt (b) by shamt, matching MIPS sll/srl/sra.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
        start_mul   = 1'b0;
        start_div   = 1'b0;
`endif
        case (bus.ALUOp)
            OP_ADD:   alu_res = bus.a + bus.b;
            OP_SUB:   alu_res = bus.a - bus.b;
            OP_RTYPE: begin
                case (bus.funcCode)
                    F_AND:   alu_res = bus.a & bus.b;
                    F_OR:    alu_res = bus.a | bus.b;
                    F_XOR:   alu_res = bus.a ^ bus.b;
                    F_NOR:   alu_res = ~(bus.a | bus.b);
                    F_ADD:   alu_res = bus.a + bus.b;
                    F_SUB:   alu_res = bus.a - bus.b;
                    F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                    F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                    F_SLL:   alu_res = bus.b << bus.shamt;
                    F_SRL:   alu_res = bus.b >> bus.shamt;
                    F_SRA:   alu_res = b_s >>> bus.shamt;
`ifdef ALU_MULDIV_EN
                    F_MFHI:  alu_res = hi_q;
                    F_MFLO:  alu_res = lo_q;
                    F_MULTU: start_mul = 1'b1;
                    F_DIVU:  start_div = 1'b1;
`endif
                    default: alu_illegal = 1'b1;
                endcase
            end
            default:  alu_illegal = 1'b1;
        endcase
    end

    // ---- stage p1: registered result / completion pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1  <= '0;
            vld_p1     <= 1'b0;
            zero_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
        end else begin
            vld_p1     <= 1'b0;
            zero_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
            if (issue && !start_md) begin
                result_p1  <= alu_res;
                vld_p1     <= 1'b1;
                zero_p1    <= (alu_res == '0);
                illegal_p1 <= alu_illegal;
            end
`ifdef ALU_MULDIV_EN
            else if (md_last) begin
                result_p1 <= '0;
                vld_p1    <= 1'b1;
                zero_p1   <= 1'b1;
            end
`endif
        end
    end

    assign bus.result       = result_p1;
    assign bus.result_valid = vld_p1;
    assign bus.zero         = zero_p1;
    assign bus.illegal      = illegal_p1;

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = (issue && start_md) ? RUN : IDLE;
            RUN:        if (cnt_q == CNT_ONE) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // One iteration: multiply shifts {acc, multiplier} right after a conditional
    // add; divide shifts {rem, quotient} left and keeps the trial subtraction if it fits.
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, operand_q});
        div_rem   = div_shift[WIDTH-1:0] - operand_q;
        if (op_div_q) begin
            step_hi = div_ok ? div_rem : div_shift[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_div_q  <= 1'b0;
            cnt_q     <= '0;
            operand_q <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (issue && start_md) begin
            op_div_q  <= start_div;
            cnt_q     <= CNT_INIT;
            operand_q <= start_div ? bus.b : bus.a;
            work_hi_q <= '0;
            work_lo_q <= start_div ? bus.a : bus.b;
        end else if (state_q == RUN) begin
            cnt_q     <= cnt_q - 1'b1;
            work_hi_q <= step_hi;
            work_lo_q <= step_lo;
            if (md_last) begin
                hi_q <= step_hi;
                lo_q <= step_lo;
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`else
    assign bus.busy = 1'b0;
    assign bus.hi   = '0;
    assign bus.lo   = '0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected responses,
// a monitor pops them on every result_valid pulse.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [4:0] sh);
        bus.valid_in = 1'b1;
        bus.ALUOp    = op;
        bus.funcCode = fn;
        bus.a        = av;
        bus.b        = bv;
        bus.shamt    = sh;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [4:0] sh, input logic [W-1:0] res, input logic ill);
        exp_t e;
        set_in(op, fn, av, bv, sh);
        e.res  = res;
        e.zero = (res == '0);
        e.ill  = ill;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_not_busy(output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: result 0x%0h with no pending op", bus.result);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result",  bus.result,  e.res);
                    check("sb_zero",    W'(bus.zero),    W'(e.zero));
                    check("sb_illegal", W'(bus.illegal), W'(e.ill));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        set_in(2'd2, 6'd32, 32'd5, 32'd7, 5'd0);
        repeat (3) step();
        check("rst_result",       bus.result, '0);
        check("rst_result_valid", W'(bus.result_valid), '0);
        check("rst_zero",         W'(bus.zero), '0);
        check("rst_illegal",      W'(bus.illegal), '0);
        check("rst_busy",         W'(bus.busy), '0);
        check("rst_hi",           bus.hi, '0);
        check("rst_lo",           bus.lo, '0);
        idle();
        rst_n = 1'b1;
        step();

        // Back-to-back single-cycle ops
        drive(2'd2, 6'd32, 32'd5,          32'd7,          5'd0, 32'd12,         1'b0);
        step();
        check("add_pulse_t1", W'(bus.result_valid), 1);
        drive(2'd2, 6'd42, 32'hFFFFFFFF,   32'd1,          5'd0, 32'd1,          1'b0);
        step();
        drive(2'd2, 6'd43, 32'hFFFFFFFF,   32'd1,          5'd0, 32'd0,          1'b0);
        step();
        drive(2'd2, 6'd34, 32'd9,          32'd9,          5'd0, 32'd0,          1'b0);
        step();
        drive(2'd3, 6'd32, 32'd5,          32'd7,          5'd0, 32'd0,          1'b1);
        step();
        drive(2'd0, 6'd0,  32'd3,          32'd4,          5'd0, 32'd7,          1'b0);
        step();
        drive(2'd1, 6'd0,  32'd3,          32'd4,          5'd0, 32'hFFFFFFFF,   1'b0);
        step();
        drive(2'd2, 6'd36, 32'hF0F01234,   32'h0FF05678,   5'd0, 32'h00F01230,   1'b0);
        step();
        drive(2'd2, 6'd37, 32'hF0F01234,   32'h0FF05678,   5'd0, 32'hFFF0567C,   1'b0);
        step();
        drive(2'd2, 6'd38, 32'hF0F01234,   32'h0FF05678,   5'd0, 32'hFF00444C,   1'b0);
        step();
        drive(2'd2, 6'd39, 32'hF0F01234,   32'h0FF05678,   5'd0, 32'h000FA983,   1'b0);
        step();
        drive(2'd2, 6'd0,  32'h80000010,   32'h80000010,   5'd4, 32'h00000100,   1'b0);
        step();
        drive(2'd2, 6'd2,  32'h80000010,   32'h80000010,   5'd4, 32'h08000001,   1'b0);
        step();
        drive(2'd2, 6'd3,  32'h80000010,   32'h80000010,   5'd4, 32'hF8000001,   1'b0);
        step();
        drive(2'd2, 6'd32, 32'hFFFFFFFF,   32'd1,          5'd0, 32'd0,          1'b0);
        step();
        drive(2'd2, 6'd63, 32'd1,          32'd2,          5'd0, 32'd0,          1'b1);
        step();
        drive(2'd2, 6'd42, 32'd3,          32'hFFFFFFFE,   5'd0, 32'd0,          1'b0);
        step();
        idle();
        step();
        check("idle_no_pulse",   W'(bus.result_valid), 0);
        check("idle_result_hold", bus.result, 32'd0);

`ifdef ALU_MULDIV_EN
        drive(2'd2, 6'd25, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd0, 1'b0);
        step();
        set_in(2'd0, 6'd0, 32'd1, 32'd1, 5'd0);
        wait_not_busy(cyc);
        check("multu_busy_cycles", cyc, 32);
        check("multu_hi", bus.hi, 32'd1);
        check("multu_lo", bus.lo, 32'hFFFFFFFE);
        drive(2'd2, 6'd18, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFE, 1'b0);
        step();
        drive(2'd2, 6'd16, 32'd0, 32'd0, 5'd0, 32'd1, 1'b0);
        step();
        idle();
        step();

        drive(2'd2, 6'd27, 32'd100, 32'd7, 5'd0, 32'd0, 1'b0);
        step();
        idle();
        wait_not_busy(cyc);
        check("divu_busy_cycles", cyc, 32);
        check("divu_lo", bus.lo, 32'd14);
        check("divu_hi", bus.hi, 32'd2);
        drive(2'd2, 6'd27, 32'd100, 32'd0, 5'd0, 32'd0, 1'b0);
        step();
        idle();
        wait_not_busy(cyc);
        check("divu0_lo", bus.lo, 32'hFFFFFFFF);
        check("divu0_hi", bus.hi, 32'd100);
        step();

        set_in(2'd2, 6'd25, 32'hFFFFFFFF, 32'd2, 5'd0);
        step();
        idle();
        repeat (9) step();
        check("multu_midrun_busy", W'(bus.busy), 1);
`else
        drive(2'd2, 6'd25, 32'd6, 32'd7, 5'd0, 32'd0, 1'b1);
        step();
        check("nomd_busy_multu", W'(bus.busy), 0);
        drive(2'd2, 6'd27, 32'd6, 32'd7, 5'd0, 32'd0, 1'b1);
        step();
        drive(2'd2, 6'd16, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        step();
        drive(2'd2, 6'd18, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("nomd_busy_idle", W'(bus.busy), 0);
        end
        check("nomd_hi", bus.hi, '0);
        check("nomd_lo", bus.lo, '0);
`endif

        // Asynchronous reset in the middle of activity
        rst_n = 1'b0;
        #1;
        check("arst_busy",         W'(bus.busy), 0);
        check("arst_hi",           bus.hi, '0);
        check("arst_lo",           bus.lo, '0);
        check("arst_result_valid", W'(bus.result_valid), 0);
        check("arst_result",       bus.result, '0);
        step();
        rst_n = 1'b1;
        step();
        drive(2'd0, 6'd0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);
        step();
        check("post_rst_add_pulse", W'(bus.result_valid), 1);
        idle();
        repeat (3) step();
        check("scoreboard_drained", W'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, registered execute-stage unit for the MIPS pipeline. It merges ALU control decode (`ALUOp`/`funcCode`) with the datapath. Single-cycle ops produce a registered result one cycle after issue. An optional iterative unsigned multiply/divide unit with HI/LO registers signals `busy` so the hazard unit can stall ID/EX.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 8 and a power of 2.
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount bits used.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  issue strobe; accepted only when `busy`=0.
- `ALUOp`  in  2  0=ADD, 1=SUB, 2=R-type (decode `funcCode`), 3=illegal.
- `funcCode`  in  6  MIPS funct field.
- `a`, `b`  in  `WIDTH`  operands (rs, rt/imm).
- `shamt`  in  `SHAMT_W`  shift amount.
- `result`  out  `WIDTH`  registered result.
- `result_valid`  out  1  one-cycle pulse per completed op.
- `zero`  out  1  `result`==0, qualified by `result_valid`.
- `illegal`  out  1  one-cycle pulse, same cycle as `result_valid`, for undecodable op.
- `busy`  out  1  multi-cycle op in progress.
- `hi`, `lo`  out  `WIDTH`  HI/LO registers.

## Operation
- Funct decode when `ALUOp`=2:
  - 36 AND, 37 OR, 38 XOR, 39 NOR
  - 32 ADD, 34 SUB (wrapping, no overflow trap)
  - 42 SLT signed, 43 SLTU unsigned; result 1 or 0
  - 0 SLL, 2 SRL, 3 SRA by `shamt`
  - 16 MFHI, 18 MFLO
  - 25 MULTU, 27 DIVU
- Any other funct, or `ALUOp`=3: `result`=0, `illegal`=1.
- MULTU: radix-2 shift-add over `WIDTH` steps; {`hi`,`lo`} = `a`×`b` (2·`WIDTH` bits).
- DIVU: restoring division over `WIDTH` steps; `lo`=quotient, `hi`=remainder.
  - `b`=0 falls out naturally: `lo`=all ones, `hi`=`a`. No trap.
- MULTU/DIVU completion: `result`=0 with a `result_valid` pulse. `hi`/`lo` change only at completion; intermediate state is internal.
- States: IDLE → (accept MULTU/DIVU) → RUN (step counter `WIDTH`..1) → DONE (one cycle, pulse) → IDLE.
- `valid_in` while `busy`=1 is ignored: no state change, no pulse.
- Reset (async, any time, including mid-RUN) clears:
  - `result`, `hi`, `lo` to 0
  - `result_valid`, `zero`, `illegal`, `busy` to 0
  - FSM to IDLE; the in-flight op is abandoned.

## Timing
- Single-cycle op issued in cycle T: `result`/`result_valid`/`zero`/`illegal` valid in T+1. Back-to-back issue every cycle is supported.
- MULTU/DIVU issued in T:
  - `busy`=1 in T+1..T+`WIDTH`.
  - In T+`WIDTH`+1: `busy`=0, `result_valid`=1, new `hi`/`lo` visible.
  - A new op is accepted in T+`WIDTH`+1.
- MFHI/MFLO issued in T+`WIDTH`+1 return the new values in T+`WIDTH`+2.
- Outputs are all registered; no combinational path from inputs to outputs.
- `result_valid`=0 in any cycle without a completion; `result` holds its last value.

## Configuration
- `ALU_MULDIV_EN` defined:
  - MULTU, DIVU, MFHI, MFLO are implemented as above.
- Undefined:
  - The FSM, counter and HI/LO registers are not built.
  - `busy`, `hi` and `lo` are tied to 0.
  - Functs 16/18/25/27 decode as illegal: `result`=0, `illegal` pulse, 1-cycle latency.

## Test plan
- Reset with `rst_n`=0, then release; issue ALUOp=2, funct 32, a=5, b=7 → T+1: `result`=12, `result_valid`=1, `zero`=0; all outputs 0 during reset.
- funct 42, a=0xFFFFFFFF, b=1 → `result`=1; funct 43, same operands → `result`=0; funct 34, a=b=9 → `result`=0, `zero`=1; ALUOp=3 → `illegal`=1, `result`=0.
- MULTU a=0xFFFFFFFF, b=2 (`WIDTH`=32) → `busy` for 32 cycles, then `hi`=1, `lo`=0xFFFFFFFE; a `valid_in` during `busy` causes no pulse; MFLO issued next → `result`=0xFFFFFFFE.
- DIVU a=100, b=7 → `lo`=14, `hi`=2; DIVU a=100, b=0 → `lo`=0xFFFFFFFF, `hi`=100.
- Drop `rst_n` at step 10 of a MULTU → `busy`=0 and `hi`=`lo`=0 immediately; after release, an ADD completes in 1 cycle.
- Build without `ALU_MULDIV_EN`, issue funct 25 → T+1: `illegal`=1, `busy` never asserted.
